// File: rtl/cpu_bus_scheduler_if.sv
// CPU/video bus-scheduler signal bundle: clock enables, video grant, frame interrupt.
// master = scheduler side, slave = CPU/video side.
interface cpu_bus_scheduler_if;
    logic pe;
    logic ne;
    logic vreq;
    logic vgnt;
    logic frame;
    logic m1;
    logic iorq;
    logic irq;

    modport master (
        output pe,
        output ne,
        output vgnt,
        output irq,
        input  vreq,
        input  frame,
        input  m1,
        input  iorq
    );

    modport slave (
        input  pe,
        input  ne,
        input  vgnt,
        input  irq,
        output vreq,
        output frame,
        output m1,
        output iorq
    );
endinterface

// File: rtl/cpu_bus_scheduler.sv
// Z80 T-state scheduler: CEN strobes, whole-T-state video bus grant with bounded burst, frame INT_n.
// Grant decided at T-state boundary, effective next T-state; video stalls freeze the CPU, never split a T-state.
module cpu_bus_scheduler #(
    parameter int unsigned DIV     = 4,
    parameter int unsigned VMAX    = 4,
    parameter int unsigned IRQ_LEN = 32
) (
    input  logic                clock,
    input  logic                reset,
    cpu_bus_scheduler_if.master bus
);
    localparam int unsigned       PW         = $clog2(DIV);
    localparam logic [PW-1:0]     P_LAST     = PW'(DIV - 1);
    localparam logic [PW-1:0]     P_HALF     = PW'(DIV / 2);
    localparam logic [7:0]        VMAX_B     = 8'(VMAX);
    localparam logic [7:0]        IRQ_LEN_B  = 8'(IRQ_LEN);

    logic [PW-1:0] p_q,    p_d;
    logic          vgnt_q, vgnt_d;
    logic [7:0]    vcnt_q, vcnt_d;
    logic          irq_q,  irq_d;
    logic [7:0]    tcnt_q, tcnt_d;
    logic          boundary;
    logic          pe;
    logic          ne;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            p_q    <= '0;
            vgnt_q <= 1'b0;
            vcnt_q <= '0;
            irq_q  <= 1'b1;
            tcnt_q <= '0;
        end else begin
            p_q    <= p_d;
            vgnt_q <= vgnt_d;
            vcnt_q <= vcnt_d;
            irq_q  <= irq_d;
            tcnt_q <= tcnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        boundary = (p_q == P_LAST);
        p_d      = boundary ? '0 : p_q + PW'(1);

        vgnt_d = vgnt_q;
        vcnt_d = vcnt_q;
        if (boundary) begin
            // vcnt==VMAX falls into the else branch: the CPU gets exactly one T-state
            if (bus.vreq && (vcnt_q < VMAX_B)) begin
                vgnt_d = 1'b1;
                vcnt_d = vcnt_q + 8'd1;
            end else begin
                vgnt_d = 1'b0;
                vcnt_d = '0;
            end
        end

        irq_d  = irq_q;
        tcnt_d = tcnt_q;
        if (bus.frame) begin
            irq_d  = 1'b0;
            tcnt_d = '0;
        end else if (!irq_q && !bus.m1 && !bus.iorq) begin
            irq_d = 1'b1;
        end else if (!irq_q && (IRQ_LEN_B != 8'd0) && pe) begin
            // timeout counts executed T-states only, so stalls stretch INT_n in clocks
            tcnt_d = tcnt_q + 8'd1;
            if ((tcnt_q + 8'd1) == IRQ_LEN_B) begin
                irq_d = 1'b1;
            end
        end
    end

    // Output decode from registered phase/grant
    always_comb begin
        pe = 1'b0;
        ne = 1'b0;
        if (!reset && !vgnt_q) begin
            pe = (p_q == '0);
            ne = (p_q == P_HALF);
        end
    end

    assign bus.pe   = pe;
    assign bus.ne   = ne;
    assign bus.vgnt = vgnt_q;
    assign bus.irq  = irq_q;

endmodule

// File: tb/tb_cpu_bus_scheduler.sv
// Bench for cpu_bus_scheduler: two instances (VMAX=4 and VMAX=1) driven identically,
// checked every clock against a T-state level reference model plus directed measurements.
module tb_cpu_bus_scheduler;
    localparam int DIV     = 4;
    localparam int IRQ_LEN = 32;
    localparam int VMAX0   = 4;
    localparam int VMAX1   = 1;
    localparam int NI      = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic vreq  = 1'b0;
    logic frame = 1'b0;
    logic m1    = 1'b1;
    logic iorq  = 1'b1;

    int total  = 0;
    int passed = 0;

    cpu_bus_scheduler_if bus0 ();
    cpu_bus_scheduler_if bus1 ();

    assign bus0.vreq  = vreq;
    assign bus0.frame = frame;
    assign bus0.m1    = m1;
    assign bus0.iorq  = iorq;
    assign bus1.vreq  = vreq;
    assign bus1.frame = frame;
    assign bus1.m1    = m1;
    assign bus1.iorq  = iorq;

    cpu_bus_scheduler #(.DIV(DIV), .VMAX(VMAX0), .IRQ_LEN(IRQ_LEN)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0.master)
    );

    cpu_bus_scheduler #(.DIV(DIV), .VMAX(VMAX1), .IRQ_LEN(IRQ_LEN)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.master)
    );

    always #5 clock = ~clock;

    // Reference model: phase within T-state, owner of the current T-state,
    // length of the current video streak, INT_n level and T-states left before timeout.
    int ph     [NI];
    bit vown   [NI];
    int streak [NI];
    bit irq_m  [NI];
    int left   [NI];

    int cnt_pe [NI];
    int cnt_ne [NI];
    int cnt_vg [NI];

    function automatic int vmax_of(input int i);
        return (i == 0) ? VMAX0 : VMAX1;
    endfunction

    function automatic logic obs_pe(input int i);
        return (i == 0) ? bus0.pe : bus1.pe;
    endfunction
    function automatic logic obs_ne(input int i);
        return (i == 0) ? bus0.ne : bus1.ne;
    endfunction
    function automatic logic obs_vg(input int i);
        return (i == 0) ? bus0.vgnt : bus1.vgnt;
    endfunction
    function automatic logic obs_irq(input int i);
        return (i == 0) ? bus0.irq : bus1.irq;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            bit e_pe;
            bit e_ne;
            e_pe = !reset && !vown[i] && (ph[i] == 0);
            e_ne = !reset && !vown[i] && (ph[i] == DIV / 2);
            chk($sformatf("pe%0d", i),   obs_pe(i),  e_pe);
            chk($sformatf("ne%0d", i),   obs_ne(i),  e_ne);
            chk($sformatf("vgnt%0d", i), obs_vg(i),  vown[i]);
            chk($sformatf("irq%0d", i),  obs_irq(i), irq_m[i]);
            if (obs_pe(i) === 1'b1) cnt_pe[i]++;
            if (obs_ne(i) === 1'b1) cnt_ne[i]++;
            if (obs_vg(i) === 1'b1) cnt_vg[i]++;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < NI; i++) begin
            bit cpu_tick;
            cpu_tick = !vown[i] && (ph[i] == 0);
            if (reset) begin
                ph[i]     = 0;
                vown[i]   = 1'b0;
                streak[i] = 0;
                irq_m[i]  = 1'b1;
                left[i]   = 0;
            end else begin
                if (ph[i] == DIV - 1) begin
                    if (vreq && streak[i] < vmax_of(i)) begin
                        vown[i] = 1'b1;
                        streak[i]++;
                    end else begin
                        vown[i]   = 1'b0;
                        streak[i] = 0;
                    end
                end
                ph[i] = (ph[i] + 1) % DIV;
                if (frame) begin
                    irq_m[i] = 1'b0;
                    left[i]  = IRQ_LEN;
                end else if (!irq_m[i] && !m1 && !iorq) begin
                    irq_m[i] = 1'b1;
                end else if (!irq_m[i] && IRQ_LEN != 0 && cpu_tick) begin
                    left[i]--;
                    if (left[i] == 0) irq_m[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clock);
        check_all();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NI; i++) begin
            cnt_pe[i] = 0;
            cnt_ne[i] = 0;
            cnt_vg[i] = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int low;
        int npe;
        int n0;
        int n1;

        clear_counts();
        reset = 1'b1;
        @(posedge clock);
        model_update();
        #1;
        repeat (2) step();

        // Release: first clock has p=0, so pe is immediately high
        reset = 1'b0;
        #1;
        chk("rel_pe_first", bus0.pe, 1'b1);
        repeat (16) step();

        // vreq raised at p=1 and held for 10 clocks
        k = 0;
        while (ph[0] != 1 && k < 2 * DIV) begin step(); k++; end
        vreq = 1'b1;
        repeat (10) step();
        vreq = 1'b0;
        repeat (20) step();

        // Permanent vreq: 20-clock pattern for VMAX=4, 8-clock pattern for VMAX=1
        vreq = 1'b1;
        repeat (60) step();
        clear_counts();
        repeat (80) step();
        chk_int("burst_vgnt_clks0", cnt_vg[0], 64);
        chk_int("burst_pe0",        cnt_pe[0], 4);
        chk_int("burst_ne0",        cnt_ne[0], 4);
        chk_int("burst_vgnt_clks1", cnt_vg[1], 40);
        chk_int("burst_pe1",        cnt_pe[1], 10);
        vreq = 1'b0;
        repeat (12) step();

        // Frame then acknowledge
        frame = 1'b1;
        step();
        frame = 1'b0;
        chk("frame_irq_low", bus0.irq, 1'b0);
        step();
        m1 = 1'b0;
        iorq = 1'b0;
        step();
        m1 = 1'b1;
        iorq = 1'b1;
        chk("ack_irq_high", bus0.irq, 1'b1);
        repeat (8) step();

        // Timeout with no video: frame on a pe clock gives 32 pe / 128 clocks low
        k = 0;
        while (ph[0] != 0 && k < 2 * DIV) begin step(); k++; end
        frame = 1'b1;
        step();
        frame = 1'b0;
        low = 0;
        npe = 0;
        for (int j = 0; j < 400 && bus0.irq === 1'b0; j++) begin
            low++;
            if (bus0.pe === 1'b1) npe++;
            step();
        end
        chk_int("timeout_low_clks", low, 128);
        chk_int("timeout_pe_cnt", npe, 32);

        // Timeout under continuous video: still 32 executed T-states on each instance
        vreq = 1'b1;
        repeat (40) step();
        k = 0;
        while (ph[0] != 0 && k < 2 * DIV) begin step(); k++; end
        frame = 1'b1;
        step();
        frame = 1'b0;
        n0 = 0;
        n1 = 0;
        k = 0;
        while ((bus0.irq === 1'b0 || bus1.irq === 1'b0) && k < 1200) begin
            if (bus0.irq === 1'b0 && bus0.pe === 1'b1) n0++;
            if (bus1.irq === 1'b0 && bus1.pe === 1'b1) n1++;
            step();
            k++;
        end
        chk_int("stall_timeout_pe0", n0, 32);
        chk_int("stall_timeout_pe1", n1, 32);

        // Frame and ack in the same clock: frame wins
        frame = 1'b1;
        m1 = 1'b0;
        iorq = 1'b0;
        step();
        frame = 1'b0;
        m1 = 1'b1;
        iorq = 1'b1;
        chk("frame_beats_ack", bus0.irq, 1'b0);

        // Reset while video owns the bus and irq is pending
        k = 0;
        while (!vown[0] && k < 50) begin step(); k++; end
        chk("pre_rst_vgnt", bus0.vgnt, 1'b1);
        chk("pre_rst_irq", bus0.irq, 1'b0);
        reset = 1'b1;
        step();
        chk("rst_vgnt", bus0.vgnt, 1'b0);
        chk("rst_irq", bus0.irq, 1'b1);
        chk("rst_pe", bus0.pe, 1'b0);
        chk("rst_ne", bus0.ne, 1'b0);
        step();
        reset = 1'b0;
        vreq = 1'b0;
        #1;
        chk("rst_rel_pe", bus0.pe, 1'b1);
        repeat (8) step();

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 7) == 0) vreq = ~vreq;
            frame = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) begin
                m1 = 1'b0;
                iorq = 1'b0;
            end else begin
                m1 = 1'b1;
                iorq = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            end
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;
        frame = 1'b0;
        m1 = 1'b1;
        iorq = 1'b1;
        repeat (4) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
